// File: rtl/msg_queue_write_arbiter.sv
// Round-robin arbiter sharing one message-queue write port between NUM_REQ producers.
// Optional feature macro ARB_TIMEOUT_EN adds the WAIT timeout and the retry limit (drop pulses).
module msg_queue_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MSG_WIDTH = 16,
  parameter int unsigned RETRY_GAP = 3,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*MSG_WIDTH-1:0]   req_msg,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             drop,
  output logic [MSG_WIDTH-1:0]           q_write,
  output logic                           q_write_en,
  input  logic                           q_done,
  input  logic                           q_write_ack,
  output logic                           busy
);

  localparam int unsigned SelW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW = $clog2(RETRY_GAP + 2);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StWait    = 2'd2;
  localparam logic [1:0] StBackoff = 2'd3;

  logic [1:0]           state_d, state_q;
  logic [SelW-1:0]      sel_d, sel_q;
  logic [SelW-1:0]      ptr_d, ptr_q;
  logic [MSG_WIDTH-1:0] q_write_d, q_write_q;
  logic [GapW-1:0]      gap_d, gap_q;
  logic [NUM_REQ-1:0]   grant_d, grant_q;
  logic [NUM_REQ-1:0]   done_mask;
  logic [NUM_REQ-1:0]   req_eff;
  logic                 arb_valid;
  logic [SelW-1:0]      arb_sel;
  logic [SelW-1:0]      ptr_inc;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [NUM_REQ-1:0] drop_d, drop_q;
  logic [ToW-1:0]     wait_cnt_d, wait_cnt_q;
  logic [1:0]         rej_cnt_d, rej_cnt_q;
  assign done_mask = grant_q | drop_q;
  assign drop      = drop_q;
`else
  assign done_mask = grant_q;
  assign drop      = '0;
`endif

  // A requester still holding req in its grant cycle is not a new message yet.
  assign req_eff = req & ~done_mask;

  always_comb begin
    int idx;
    arb_valid = 1'b0;
    arb_sel   = '0;
    // Descending scan so the lowest offset from ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NUM_REQ);
      if (req_eff[idx]) begin
        arb_valid = 1'b1;
        arb_sel   = SelW'(idx);
      end
    end
  end

  assign ptr_inc = (sel_q == SelW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    int base;
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    q_write_d = q_write_q;
    gap_d     = gap_q;
    grant_d   = '0;
    base      = int'(arb_sel) * int'(MSG_WIDTH);
`ifdef ARB_TIMEOUT_EN
    drop_d     = '0;
    wait_cnt_d = wait_cnt_q;
    rej_cnt_d  = rej_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          sel_d     = arb_sel;
          q_write_d = req_msg[base +: MSG_WIDTH];
          state_d   = StIssue;
`ifdef ARB_TIMEOUT_EN
          rej_cnt_d = '0;
`endif
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      StWait: begin
        if (q_done) begin
          if (q_write_ack) begin
            grant_d[sel_q] = 1'b1;
            ptr_d          = ptr_inc;
            state_d        = StIdle;
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (rej_cnt_q == 2'd3) begin
              drop_d[sel_q] = 1'b1;
              ptr_d         = ptr_inc;
              state_d       = StIdle;
            end else begin
              rej_cnt_d = rej_cnt_q + 1'b1;
              gap_d     = GapW'(RETRY_GAP);
              state_d   = StBackoff;
            end
`else
            gap_d   = GapW'(RETRY_GAP);
            state_d = StBackoff;
`endif
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_cnt_q == ToW'(TIMEOUT - 1)) begin
          drop_d[sel_q] = 1'b1;
          ptr_d         = ptr_inc;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      StBackoff: begin
        // Gap counts the idle cycles between the rejecting done and the re-issue.
        if (gap_q <= GapW'(1)) begin
          state_d = StIssue;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      ptr_q     <= '0;
      q_write_q <= '0;
      gap_q     <= '0;
      grant_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      drop_q     <= '0;
      wait_cnt_q <= '0;
      rej_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      q_write_q <= q_write_d;
      gap_q     <= gap_d;
      grant_q   <= grant_d;
`ifdef ARB_TIMEOUT_EN
      drop_q     <= drop_d;
      wait_cnt_q <= wait_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign q_write    = q_write_q;
  assign q_write_en = (state_q == StIssue);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_msg_queue_write_arbiter.sv
// Scoreboard bench for msg_queue_write_arbiter: expected grants/drops are queued at stimulus
// time and checked when the DUT pulses them; a small queue model answers each strobe.
module tb_msg_queue_write_arbiter;

  localparam int NR  = 4;
  localparam int MW  = 16;
  localparam int GAP = 3;
  localparam int TO  = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*MW-1:0]  req_msg = '0;
  logic [NR-1:0]     grant, drop;
  logic [MW-1:0]     q_write;
  logic              q_write_en;
  logic              q_done = 1'b0;
  logic              q_write_ack = 1'b0;
  logic              busy;

  always #5 clock = ~clock;

  msg_queue_write_arbiter #(
    .NUM_REQ  (NR),
    .MSG_WIDTH(MW),
    .RETRY_GAP(GAP),
    .TIMEOUT  (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_msg    (req_msg),
    .grant      (grant),
    .drop       (drop),
    .q_write    (q_write),
    .q_write_en (q_write_en),
    .q_done     (q_done),
    .q_write_ack(q_write_ack),
    .busy       (busy)
  );

  typedef struct {
    bit          is_drop;
    int          idx;
    logic [MW-1:0] msg;
  } exp_t;

  exp_t          sb[$];
  bit            ack_plan[$];
  logic [MW-1:0] writes[$];
  int            strobe_cycs[$];
  int            n_checks = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            respond_en = 1'b1;
  bit            auto_release = 1'b1;
  bit            pending = 1'b0;
  int            strobe_cnt = 0;
  int            last_strobe_cyc = 0;
  int            event_cnt = 0;
  int            last_ev_cyc = 0;
  logic [MW-1:0] last_write = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: sample at the falling edge, run the queue model and the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    q_done      = 1'b0;
    q_write_ack = 1'b0;
    if (pending) begin
      q_done      = 1'b1;
      q_write_ack = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b1;
      pending     = 1'b0;
    end
    if (q_write_en && respond_en && !reset) pending = 1'b1;
    if (q_write_en) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      last_write      = q_write;
      writes.push_back(q_write);
      strobe_cycs.push_back(cyc);
    end
    if (grant != '0 || drop != '0) begin
      event_cnt++;
      last_ev_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("unexpected_event", {grant, drop}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_drop) begin
          check_eq("drop_onehot", drop, 32'd1 << e.idx);
          check_eq("drop_no_grant", grant, 32'd0);
        end else begin
          check_eq("grant_onehot", grant, 32'd1 << e.idx);
          check_eq("grant_no_drop", drop, 32'd0);
        end
        check_eq("event_data", last_write, e.msg);
      end
      if (auto_release) req = req & ~(grant | drop);
    end
  endtask

  task automatic push(input bit is_drop, input int idx, input logic [MW-1:0] msg);
    exp_t e;
    e.is_drop = is_drop;
    e.idx     = idx;
    e.msg     = msg;
    sb.push_back(e);
  endtask

  task automatic set_msg(input int idx, input logic [MW-1:0] val);
    req_msg[idx*MW +: MW] = val;
  endtask

  task automatic wait_events(input int target, input int budget);
    int start;
    start = cyc;
    while (event_cnt < target && (cyc - start) < budget) tick();
    if (event_cnt < target) check_eq("wait_event_bound", event_cnt, target);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int start;
    start = cyc;
    while (strobe_cnt < target && (cyc - start) < budget) tick();
    if (strobe_cnt < target) check_eq("wait_strobe_bound", strobe_cnt, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    int ev0;
    int sc0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wen", q_write_en, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_qwrite", q_write, 0);
    reset = 1'b0;

    // No requests: nothing happens
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_wen", q_write_en, 0);
      check_eq("idle_grant", grant, 0);
      check_eq("idle_busy", busy, 0);
    end

    // Single request, latency N+1 strobe / N+3 grant
    set_msg(0, 16'h00A5);
    push(1'b0, 0, 16'h00A5);
    req = 4'b0001;
    n0  = cyc;
    ev0 = event_cnt;
    wait_events(ev0 + 1, 20);
    check_eq("t2_wen_cycle", last_strobe_cyc - n0, 1);
    check_eq("t2_write", last_write, 16'h00A5);
    check_eq("t2_grant_cycle", last_ev_cyc - n0, 3);

    // ptr now 1: with req 0 and 3 pending, 3 must win before 0
    tick();
    set_msg(0, 16'h1111);
    set_msg(3, 16'h3333);
    push(1'b0, 3, 16'h3333);
    push(1'b0, 0, 16'h1111);
    req = 4'b1001;
    ev0 = event_cnt;
    wait_events(ev0 + 2, 40);

    // All requesting from ptr 0: order 0,1,2,3,0
    do_reset();
    auto_release = 1'b0;
    for (int i = 0; i < NR; i++) set_msg(i, MW'(16'hC000 + i));
    push(1'b0, 0, 16'hC000);
    push(1'b0, 1, 16'hC001);
    push(1'b0, 2, 16'hC002);
    push(1'b0, 3, 16'hC003);
    push(1'b0, 0, 16'hC000);
    req = 4'b1111;
    ev0 = event_cnt;
    wait_events(ev0 + 5, 80);
    req = '0;
    auto_release = 1'b1;
    repeat (3) tick();
    check_eq("t3_idle_after", busy, 0);

    // Two rejections then accept: three strobes, RETRY_GAP idle cycles after each done
    set_msg(2, 16'h5A5A);
    push(1'b0, 2, 16'h5A5A);
    ack_plan.push_back(1'b0);
    ack_plan.push_back(1'b0);
    writes.delete();
    strobe_cycs.delete();
    req = 4'b0100;
    ev0 = event_cnt;
    tick();
    set_msg(2, 16'hFFFF);
    wait_events(ev0 + 1, 80);
    check_eq("t4_strobes", writes.size(), 3);
    for (int i = 0; i < writes.size(); i++) check_eq("t4_data", writes[i], 16'h5A5A);
    for (int i = 1; i < strobe_cycs.size(); i++)
      check_eq("t4_retry_spacing", strobe_cycs[i] - strobe_cycs[i-1], GAP + 2);

    // Reset during WAIT aborts; held req is re-issued afterwards
    repeat (2) tick();
    set_msg(0, 16'h0BEE);
    push(1'b0, 0, 16'h0BEE);
    respond_en = 1'b0;
    req = 4'b0001;
    wait_strobes(strobe_cnt + 1, 10);
    tick();
    check_eq("t5_busy_wait", busy, 1);
    ev0 = event_cnt;
    reset = 1'b1;
    tick();
    check_eq("t5_busy_rst", busy, 0);
    check_eq("t5_grant_rst", grant, 0);
    check_eq("t5_wen_rst", q_write_en, 0);
    check_eq("t5_qwrite_rst", q_write, 0);
    reset = 1'b0;
    respond_en = 1'b1;
    sc0 = strobe_cnt;
    wait_events(ev0 + 1, 20);
    check_eq("t5_reissue", strobe_cnt - sc0, 1);

`ifdef ARB_TIMEOUT_EN
    // No done ever: drop after TIMEOUT WAIT cycles, ptr moves to 2
    repeat (2) tick();
    set_msg(1, 16'h7777);
    push(1'b1, 1, 16'h7777);
    respond_en = 1'b0;
    req = 4'b0010;
    ev0 = event_cnt;
    wait_strobes(strobe_cnt + 1, 10);
    n0 = last_strobe_cyc;
    wait_events(ev0 + 1, 40);
    check_eq("t6_drop_cycle", last_ev_cyc - n0, TO + 1);
    respond_en = 1'b1;
    repeat (2) tick();
    set_msg(0, 16'hA000);
    set_msg(1, 16'hA001);
    set_msg(2, 16'hA002);
    push(1'b0, 2, 16'hA002);
    push(1'b0, 0, 16'hA000);
    push(1'b0, 1, 16'hA001);
    req = 4'b0111;
    ev0 = event_cnt;
    wait_events(ev0 + 3, 60);
`endif

    repeat (5) tick();
    check_eq("sb_empty", sb.size(), 0);
    check_eq("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
